fake_psx_pad: RTL and testbench

//   Device-side emulator of a PSX controller: responds to a PSX host (att/psx_clk/cmd) with the

---
 rtl/fake_psx_pad_pkg.sv | 39 +++
 rtl/psx_sync_edge.sv | 42 ++++
 rtl/fake_psx_pad.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_fake_psx_pad.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fake_psx_pad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fake_psx_pad_pkg                                                  |
// | Brief  : Shared protocol constants and state encoding for the PSX pad      |
// |          emulator. The same constants serve the host-side initiator.       |
// | Config : FAKE_PSX_PAD_ANALOG_EN selects the analog (8'h73) reply frame.    |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package fake_psx_pad_pkg;

  // Protocol bytes
  localparam logic [7:0] PSX_CMD_START  = 8'h01;
  localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
  localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
  localparam logic [7:0] PSX_ID_ANALOG  = 8'h73;
  localparam logic [7:0] PSX_PAD_MAGIC  = 8'h5A;
  localparam logic [7:0] PSX_PAD_HIZ    = 8'hFF;

  // Reply frame shape depends on the build flavour
`ifdef FAKE_PSX_PAD_ANALOG_EN
  localparam logic [7:0] PSX_PAD_ID   = PSX_ID_ANALOG;
  localparam logic [3:0] PSX_LAST_IDX = 4'd8;
`else
  localparam logic [7:0] PSX_PAD_ID   = PSX_ID_DIGITAL;
  localparam logic [3:0] PSX_LAST_IDX = 4'd4;
`endif

  // Pad state machine encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_ACK_WAIT  = 3'd3,
    ST_ACK_PULSE = 3'd4,
    ST_IGNORE    = 3'd5
  } psx_state_t;

endpackage : fake_psx_pad_pkg
`default_nettype wire

// File: rtl/psx_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : psx_sync_edge                                                     |
// | Brief  : Multi-flop synchronizer for one asynchronous pad pin, with        |
// |          single-cycle rise/fall pulses derived from the synchronized value.|
// | Ports  : clk, rst        - system clock, synchronous active-high reset     |
// |          i_async         - asynchronous input pin                          |
// |          o_sync          - synchronized level                              |
// |          o_rise, o_fall  - 1-cycle edge pulses on o_sync                   |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module psx_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // All pad pins idle high, so reset the chain high to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule : psx_sync_edge
`default_nettype wire

// File: rtl/fake_psx_pad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fake_psx_pad                                                      |
// | Brief  : Device-side PSX controller emulator. Answers a host poll          |
// |          (att/psx_clk/cmd) with the standard reply on data and pulses ack  |
// |          between bytes. All pad pins are oversampled on clk.               |
// | Config : FAKE_PSX_PAD_ANALOG_EN adds the sticks port and the analog frame. |
// | Ports  : clk, rst          - system clock (>= 8x psx_clk), sync reset      |
// |          att, psx_clk, cmd - host pins (async), att active low             |
// |          buttons[15:0]     - button state, active low, latched at att fall |
// |          sticks[31:0]      - RX,RY,LX,LY (analog build only)               |
// |          data, ack         - pad->host serial / ack (active low)           |
// |          rx_byte, rx_valid - last received command byte + update pulse     |
// |          poll_done         - pulse when a full poll completes              |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module fake_psx_pad
  import fake_psx_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DELAY   = 20,
  parameter int ACK_WIDTH   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        att,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] buttons,
`ifdef FAKE_PSX_PAD_ANALOG_EN
  input  logic [31:0] sticks,
`endif
  output logic        data,
  output logic        ack,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        poll_done
);

  localparam int ACK_MAX   = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int ACK_CNT_W = $clog2(ACK_MAX + 1);

  // ---------------------------------------------------------------- inputs
  logic w_att_sync, w_att_rise, w_att_fall;
  logic w_pclk_sync, w_pclk_rise, w_pclk_fall;
  logic w_cmd_sync, w_cmd_rise, w_cmd_fall;

  psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_att (
    .clk(clk), .rst(rst), .i_async(att),
    .o_sync(w_att_sync), .o_rise(w_att_rise), .o_fall(w_att_fall)
  );

  psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pclk (
    .clk(clk), .rst(rst), .i_async(psx_clk),
    .o_sync(w_pclk_sync), .o_rise(w_pclk_rise), .o_fall(w_pclk_fall)
  );

  psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cmd (
    .clk(clk), .rst(rst), .i_async(cmd),
    .o_sync(w_cmd_sync), .o_rise(w_cmd_rise), .o_fall(w_cmd_fall)
  );

  // Only levels/edges that matter are consumed; the rest are intentionally dropped.
  logic w_unused_sync;
  assign w_unused_sync = &{1'b0, w_att_sync, w_pclk_sync, w_cmd_rise, w_cmd_fall};

  // ---------------------------------------------------------------- registers
  psx_state_t          r_state, w_next_state;
  logic [15:0]         r_btn;
`ifdef FAKE_PSX_PAD_ANALOG_EN
  logic [31:0]         r_stk;
`endif
  logic [7:0]          r_tx_sr;
  logic [6:0]          r_rx_sr;
  logic [2:0]          r_bit_cnt;
  logic [3:0]          r_idx;
  logic                r_data;
  logic [7:0]          r_rx_byte;
  logic                r_rx_valid;
  logic                r_poll_done;
  logic                r_ack_busy;
  logic                r_ack_low;
  logic [ACK_CNT_W-1:0] r_ack_cnt;

  // ---------------------------------------------------------------- decode
  logic [7:0] w_reply;
  logic [7:0] w_tx_src;
  logic [7:0] w_rx_next;
  logic       w_in_frame;
  logic       w_byte_done;
  logic       w_byte_bad;
  logic       w_last_idx;
  logic       w_ack_fire;
  logic       w_ack_end;
  logic       w_ack_start;
  logic       w_poll_done;

  // Reply byte for the current frame index, built from the latched inputs.
  always_comb begin
    w_reply = PSX_PAD_HIZ;
    case (r_idx)
      4'd0:    w_reply = PSX_PAD_HIZ;
      4'd1:    w_reply = PSX_PAD_ID;
      4'd2:    w_reply = PSX_PAD_MAGIC;
      4'd3:    w_reply = r_btn[7:0];
      4'd4:    w_reply = r_btn[15:8];
`ifdef FAKE_PSX_PAD_ANALOG_EN
      4'd5:    w_reply = r_stk[7:0];
      4'd6:    w_reply = r_stk[15:8];
      4'd7:    w_reply = r_stk[23:16];
      4'd8:    w_reply = r_stk[31:24];
`endif
      default: w_reply = PSX_PAD_HIZ;
    endcase
  end

  assign w_in_frame = (r_state == ST_LOAD) || (r_state == ST_SHIFT) ||
                      (r_state == ST_ACK_WAIT) || (r_state == ST_ACK_PULSE);

  // Outside SHIFT the next byte has not been loaded yet (an early host edge
  // during the ack window), so shift straight from the reply table.
  assign w_tx_src    = (r_state == ST_SHIFT) ? r_tx_sr : w_reply;
  assign w_rx_next   = {w_cmd_sync, r_rx_sr};
  assign w_byte_done = (r_state == ST_SHIFT) && w_pclk_rise && (r_bit_cnt == 3'd7);
  assign w_byte_bad  = ((r_idx == 4'd0) && (w_rx_next != PSX_CMD_START)) ||
                       ((r_idx == 4'd1) && (w_rx_next != PSX_CMD_POLL));
  assign w_last_idx  = (r_idx == PSX_LAST_IDX);
  assign w_ack_fire  = r_ack_busy && !r_ack_low && (r_ack_cnt == '0);
  assign w_ack_end   = r_ack_busy &&  r_ack_low && (r_ack_cnt == '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ack_start  = 1'b0;
    w_poll_done  = 1'b0;
    if (w_att_rise) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_att_fall) w_next_state = ST_LOAD;
        end
        ST_LOAD: begin
          w_next_state = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_byte_done) begin
            if (w_byte_bad) begin
              w_next_state = ST_IGNORE;
            end else if (w_last_idx) begin
              w_next_state = ST_IGNORE;
              w_poll_done  = 1'b1;
            end else begin
              w_next_state = ST_ACK_WAIT;
              w_ack_start  = 1'b1;
            end
          end
        end
        ST_ACK_WAIT: begin
          if (w_pclk_rise || w_pclk_fall) w_next_state = ST_SHIFT;
          else if (w_ack_fire)            w_next_state = ST_ACK_PULSE;
        end
        ST_ACK_PULSE: begin
          if (w_pclk_rise || w_pclk_fall) w_next_state = ST_SHIFT;
          else if (w_ack_end)             w_next_state = ST_LOAD;
        end
        ST_IGNORE: begin
          w_next_state = ST_IGNORE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn       <= 16'hFFFF;
`ifdef FAKE_PSX_PAD_ANALOG_EN
      r_stk       <= 32'h0000_0000;
`endif
      r_tx_sr     <= PSX_PAD_HIZ;
      r_rx_sr     <= 7'd0;
      r_bit_cnt   <= 3'd0;
      r_idx       <= 4'd0;
      r_data      <= 1'b1;
      r_rx_byte   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_poll_done <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_poll_done <= w_poll_done;
      if (w_att_rise) begin
        r_data    <= 1'b1;
        r_tx_sr   <= PSX_PAD_HIZ;
        r_rx_sr   <= 7'd0;
        r_bit_cnt <= 3'd0;
        r_idx     <= 4'd0;
      end else begin
        if ((r_state == ST_IDLE) && w_att_fall) begin
          r_btn     <= buttons;
`ifdef FAKE_PSX_PAD_ANALOG_EN
          r_stk     <= sticks;
`endif
          r_idx     <= 4'd0;
          r_bit_cnt <= 3'd0;
        end

        // Preset bit 0 so it is on the line before the first psx_clk fall.
        if (r_state == ST_LOAD) begin
          r_tx_sr <= w_reply;
          r_data  <= w_reply[0];
        end

        if (w_in_frame) begin
          if (w_pclk_fall) begin
            r_data  <= w_tx_src[0];
            r_tx_sr <= {1'b1, w_tx_src[7:1]};
          end else if (w_pclk_rise) begin
            r_rx_sr   <= w_rx_next[7:1];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_state != ST_SHIFT) begin
              r_tx_sr <= w_reply;
              r_data  <= w_reply[0];
            end
          end
        end

        if (w_byte_done) begin
          r_rx_byte  <= w_rx_next;
          r_rx_valid <= 1'b1;
          if (!w_byte_bad && !w_last_idx) begin
            r_idx <= (r_idx == PSX_LAST_IDX) ? r_idx : r_idx + 4'd1;
          end
        end

        // Release the line once the frame is finished or rejected.
        if ((r_state == ST_IGNORE) || (w_byte_done && (w_byte_bad || w_last_idx))) begin
          r_data <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- ack timer
  // Runs independently of the FSM so a fast host that starts the next byte
  // early still sees a full-length ack pulse.
  always_ff @(posedge clk) begin
    if (rst || w_att_rise) begin
      r_ack_busy <= 1'b0;
      r_ack_low  <= 1'b0;
      r_ack_cnt  <= '0;
    end else if (w_ack_start) begin
      r_ack_busy <= 1'b1;
      r_ack_low  <= 1'b0;
      r_ack_cnt  <= ACK_CNT_W'(ACK_DELAY - 2);
    end else if (r_ack_busy) begin
      if (r_ack_cnt != '0) begin
        r_ack_cnt <= r_ack_cnt - ACK_CNT_W'(1);
      end else if (!r_ack_low) begin
        r_ack_low <= 1'b1;
        r_ack_cnt <= ACK_CNT_W'(ACK_WIDTH - 1);
      end else begin
        r_ack_busy <= 1'b0;
        r_ack_low  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign data      = r_data;
  assign ack       = ~r_ack_low;
  assign rx_byte   = r_rx_byte;
  assign rx_valid  = r_rx_valid;
  assign poll_done = r_poll_done;

endmodule : fake_psx_pad
`default_nettype wire

// File: tb/tb_fake_psx_pad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_fake_psx_pad                                                   |
// | Brief  : Self-checking bench for fake_psx_pad. A host model drives         |
// |          att/psx_clk/cmd; expected replies come from a frame-level model.  |
// | Config : FAKE_PSX_PAD_ANALOG_EN selects the analog frame and sticks port.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fake_psx_pad;

  localparam int SYNC = 2;
  localparam int AD   = 20;
  localparam int AW   = 6;
  localparam int HALF = 10;
`ifdef FAKE_PSX_PAD_ANALOG_EN
  localparam int         LAST = 8;
  localparam logic [7:0] ID   = 8'h73;
`else
  localparam int         LAST = 4;
  localparam logic [7:0] ID   = 8'h41;
`endif

  logic        clk = 1'b0;
  logic        rst, att, psx_clk, cmd;
  logic [15:0] buttons;
  logic [31:0] sticks;
  logic        data, ack, rx_valid, poll_done;
  logic [7:0]  rx_byte;

  int checks = 0;
  int errors = 0;
  int n_rxv = 0, n_pd = 0, n_acklow = 0;
  logic [7:0] seen_rx = 8'h00;

  always #5 clk = ~clk;

  fake_psx_pad #(.SYNC_STAGES(SYNC), .ACK_DELAY(AD), .ACK_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .att      (att),
    .psx_clk  (psx_clk),
    .cmd      (cmd),
    .buttons  (buttons),
`ifdef FAKE_PSX_PAD_ANALOG_EN
    .sticks   (sticks),
`endif
    .data     (data),
    .ack      (ack),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .poll_done(poll_done)
  );

  // Event monitor on the inactive edge
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_rxv   = n_rxv + 1;
      seen_rx = rx_byte;
    end
    if (poll_done === 1'b1) n_pd = n_pd + 1;
    if (ack === 1'b0) n_acklow = n_acklow + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One host byte, LSB first; returns with psx_clk just raised for bit 7.
  task automatic xfer(input logic [7:0] c, output logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      psx_clk = 1'b0;
      cmd     = c[i];
      repeat (HALF) @(negedge clk);
      d[i]    = data;
      psx_clk = 1'b1;
      if (i != 7) repeat (HALF - 1) @(negedge clk);
    end
  endtask

  task automatic ack_expect(input int k);
    int d = 0;
    int w = 0;
    while (ack !== 1'b0 && d < 100) begin
      @(negedge clk);
      d++;
    end
    chk($sformatf("ack_delay_b%0d", k), d, AD + SYNC);
    while (ack === 1'b0 && w < 100) begin
      w++;
      @(negedge clk);
    end
    chk($sformatf("ack_width_b%0d", k), w, AW);
    repeat (4) @(negedge clk);
  endtask

  task automatic ack_none(input int k);
    int n0 = n_acklow;
    repeat (AD + AW + SYNC + 8) @(negedge clk);
    chk($sformatf("no_ack_b%0d", k), n_acklow - n0, 0);
  endtask

  // Full frame against a model of the poll protocol.
  task automatic run_frame(input int nb, input logic [7:0] c0, input logic [7:0] c1,
                           input logic [15:0] bl, input logic [15:0] bm,
                           input logic [31:0] stk, input bit rnd_tail);
    logic [7:0] tab [0:8];
    logic [7:0] c, d, exp_last;
    int  rv0, pd0, exp_rx, exp_pd;
    bit  alive, ok;
    tab[0] = 8'hFF; tab[1] = ID;          tab[2] = 8'h5A;
    tab[3] = bl[7:0]; tab[4] = bl[15:8];
    tab[5] = stk[7:0]; tab[6] = stk[15:8]; tab[7] = stk[23:16]; tab[8] = stk[31:24];
    @(negedge clk);
    buttons = bl;
    sticks  = stk;
    @(negedge clk);
    att = 1'b0;
    repeat (6) @(negedge clk);
    buttons  = bm;
    sticks   = ~stk;
    rv0      = n_rxv;
    pd0      = n_pd;
    exp_rx   = 0;
    exp_pd   = 0;
    exp_last = 8'h00;
    alive    = 1'b1;
    for (int k = 0; k < nb; k++) begin
      if (k == 0)        c = c0;
      else if (k == 1)   c = c1;
      else if (rnd_tail) c = 8'($urandom);
      else               c = 8'h00;
      xfer(c, d);
      chk($sformatf("data_b%0d", k), d, alive ? tab[k] : 8'hFF);
      if (alive) begin
        exp_rx++;
        exp_last = c;
        ok = !((k == 0) && (c != 8'h01)) && !((k == 1) && (c != 8'h42));
        if (ok && k < LAST) ack_expect(k);
        else begin
          if (ok) exp_pd = 1;
          ack_none(k);
        end
        alive = ok && (k < LAST);
      end else begin
        ack_none(k);
      end
    end
    @(negedge clk);
    att = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    chk("end_data", data, 1'b1);
    chk("end_ack", ack, 1'b1);
    chk("rx_count", n_rxv - rv0, exp_rx);
    chk("rx_byte", rx_byte, exp_last);
    chk("rx_seen", seen_rx, exp_last);
    chk("poll_done_count", n_pd - pd0, exp_pd);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    int n0, pd0, t;
    rst = 1'b1; att = 1'b1; psx_clk = 1'b1; cmd = 1'b1;
    buttons = 16'hFFFF; sticks = 32'h0;
    repeat (5) @(negedge clk);
    chk("rst_data", data, 1'b1);
    chk("rst_ack", ack, 1'b1);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_poll_done", poll_done, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Standard digital poll
    run_frame(LAST + 1, 8'h01, 8'h42, 16'hFFFE, 16'hFFFE, 32'h0, 1'b0);
    // Bad start byte: rejected frame
    run_frame(5, 8'h81, 8'h42, 16'h1234, 16'h1234, 32'h0, 1'b0);
    // Bad poll byte
    run_frame(4, 8'h01, 8'h43, 16'h5555, 16'h5555, 32'h0, 1'b0);
    // Buttons change mid-frame are not seen
    run_frame(LAST + 1, 8'h01, 8'h42, 16'h0000, 16'hFFFF, 32'hA5C3_0F96, 1'b0);

    // att raised after two bytes, during the pending ack
    att = 1'b0;
    repeat (6) @(negedge clk);
    xfer(8'h01, d);
    chk("abort_b0", d, 8'hFF);
    ack_expect(0);
    xfer(8'h42, d);
    chk("abort_b1", d, ID);
    n0  = n_acklow;
    pd0 = n_pd;
    repeat (5) @(negedge clk);
    att = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    chk("abort_data", data, 1'b1);
    chk("abort_ack", ack, 1'b1);
    repeat (AD + AW) @(negedge clk);
    chk("abort_no_ack", n_acklow - n0, 0);
    chk("abort_no_poll", n_pd - pd0, 0);
    run_frame(LAST + 1, 8'h01, 8'h42, 16'h7EBD, 16'h7EBD, 32'h1122_3344, 1'b1);

    // Reset during the ack pulse
    att = 1'b0;
    repeat (6) @(negedge clk);
    xfer(8'h01, d);
    t = 0;
    while (ack !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_ack_seen", ack, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack", ack, 1'b1);
    chk("rst_mid_data", data, 1'b1);
    chk("rst_mid_rx_byte", rx_byte, 8'h00);
    rst = 1'b0;
    att = 1'b1;
    repeat (10) @(negedge clk);
    run_frame(LAST + 1, 8'h01, 8'h42, 16'hC001, 16'hC001, 32'h0, 1'b0);

`ifdef FAKE_PSX_PAD_ANALOG_EN
    run_frame(LAST + 1, 8'h01, 8'h42, 16'hBEEF, 16'hBEEF, 32'h807F_10F0, 1'b0);
`endif

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      logic [7:0]  r0, r1;
      logic [15:0] bl, bm;
      logic [31:0] sk;
      r0 = ($urandom_range(0, 3) != 0) ? 8'h01 : 8'($urandom);
      r1 = ($urandom_range(0, 3) != 0) ? 8'h42 : 8'($urandom);
      bl = 16'($urandom);
      bm = 16'($urandom);
      sk = $urandom;
      run_frame($urandom_range(1, LAST + 2), r0, r1, bl, bm, sk, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fake_psx_pad
`default_nettype wire
